// File: rtl/fft_result_capture.sv
// fft_result_capture: stores one FFT frame as |re|+|im| magnitudes and
// tracks the peak bin; exposes the stored frame through a 1-cycle read port.
// Ports: clk, rst_n, start, opd/xk_idx/xk_re/xk_im (FFT output stream),
//        busy, done, seq_err, peak_idx, peak_mag, rd_en/rd_addr -> rd_data/rd_valid.
module fft_result_capture #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 10,
  parameter bit SKIP_DC = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              opd,
  input  logic [ADDR_W-1:0] xk_idx,
  input  logic [DATA_W-1:0] xk_re,
  input  logic [DATA_W-1:0] xk_im,
  output logic              busy,
  output logic              done,
  output logic              seq_err,
  output logic [ADDR_W-1:0] peak_idx,
  output logic [DATA_W:0]   peak_mag,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W:0]   rd_data,
  output logic              rd_valid
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W:0]   ONE  = (DATA_W + 1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] wcnt;
  logic [DATA_W:0]   mem [DEPTH];

  logic [DATA_W:0]   re_x;
  logic [DATA_W:0]   im_x;
  logic [DATA_W:0]   abs_re;
  logic [DATA_W:0]   abs_im;
  logic [DATA_W:0]   mag;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              elig;
  logic              pk_upd;

  // Sign-extend by one bit so the most negative input negates without overflow.
  always_comb begin
    re_x   = {xk_re[DATA_W-1], xk_re};
    im_x   = {xk_im[DATA_W-1], xk_im};
    abs_re = xk_re[DATA_W-1] ? (~re_x + ONE) : re_x;
    abs_im = xk_im[DATA_W-1] ? (~im_x + ONE) : im_x;
    mag    = abs_re + abs_im;
  end

  // Bin 0 is only accepted from ARMED; CAPTURE writes at the running count.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    unique case (1'b1)
      state == ARMED:   wr_en = opd && (xk_idx == '0);
      state == CAPTURE: begin
        wr_en   = opd;
        wr_addr = wcnt;
      end
      default: ;
    endcase
    elig   = !SKIP_DC || (wr_addr != '0);
    pk_upd = wr_en && elig && (mag > peak_mag);
  end

  assign busy = (state == ARMED) || (state == CAPTURE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= mag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wcnt     <= '0;
      seq_err  <= 1'b0;
      peak_idx <= '0;
      peak_mag <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en && (state == DONE);
      if (rd_en && (state == DONE)) rd_data <= mem[rd_addr];

      if (pk_upd) begin
        peak_idx <= wr_addr;
        peak_mag <= mag;
      end

      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= ARMED;
            seq_err  <= 1'b0;
            peak_idx <= '0;
            peak_mag <= '0;
          end
        end
        ARMED: begin
          if (opd && (xk_idx == '0)) begin
            state <= CAPTURE;
            wcnt  <= ADDR_W'(1);
          end
        end
        CAPTURE: begin
          if (opd) begin
            wcnt <= wcnt + ADDR_W'(1);
            if (xk_idx != wcnt) seq_err <= 1'b1;
            if (wcnt == LAST) state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
